commit_trace_buffer: RTL
========================

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter: DEPTH, default 8, FIFO entry count; power of two, 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: commit  input  1  one instruction retires this cycle (CPU writeback-stage commit).
REQ-005 Port: commit_pc  input  32  PC of retiring instruction.
REQ-006 Port: commit_pre_pc  input  32  fetch-predicted next PC of retiring instruction.
REQ-007 Port: trace_valid  output  1  FIFO head holds a record.
REQ-008 Port: trace_ready  input  1  consumer accepts head record.
REQ-009 Port: trace_pc  output  32  head record PC.
REQ-010 Port: trace_pre_pc  output  32  head record predicted next PC.
REQ-011 Port: trace_redirect  output  1  head record's PC differs from the previous commit's pre_pc.
REQ-012 Port: retire_cnt  output  32  total commits seen, including dropped ones.
REQ-013 Port: redirect_cnt  output  32  total commits flagged redirect.
REQ-014 Port: drop_cnt  output  16  commits lost because FIFO full.
REQ-015 Port: overflow  output  1  sticky, set on first drop.
REQ-016 Port: level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Record = {commit_pc, commit_pre_pc, redirect}; FIFO is first-word fall-through: trace_* reflect the head combinationally whenever trace_valid=1.
REQ-018 trace_valid SHALL equal (level != 0); trace_pc/trace_pre_pc/trace_redirect are don't-care when trace_valid=0.
REQ-019 Pop occurs on a cycle with trace_valid && trace_ready; a pop when empty SHALL have no effect.
REQ-020 Push occurs on a cycle with commit && (level < DEPTH || pop this cycle); pushed record is visible at head no earlier than the next cycle.
REQ-021 Simultaneous push and pop SHALL leave level unchanged, including at level = DEPTH and at level = 1.
REQ-022 commit while level = DEPTH and no pop: record dropped, drop_cnt += 1 (saturating at 0xFFFF), overflow set to 1; FIFO contents unchanged.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; ordering SHALL be strict FIFO across wrap.
REQ-024 Internal last_pre_pc register and has_prev flag: on every commit (pushed or dropped) last_pre_pc <= commit_pre_pc, has_prev <= 1.
REQ-025 redirect = has_prev && (commit_pc != last_pre_pc); first commit after reset SHALL have redirect = 0.
REQ-026 retire_cnt += 1 on every commit; redirect_cnt += 1 on every commit with redirect = 1; both wrap 0xFFFFFFFF -> 0.
REQ-027 All counters and status outputs are registered; they reflect a commit on the cycle after it.
REQ-028 Latency commit -> trace_valid on an empty FIFO: exactly 1 cycle.

Reset
REQ-029 rst=1 at a rising edge SHALL clear level, pointers, retire_cnt, redirect_cnt, drop_cnt, overflow, has_prev, last_pre_pc (to 0); trace_valid = 0 the following cycle.
REQ-030 commit and trace_ready SHALL be ignored on any cycle with rst=1; reset mid-stream discards all buffered records.
REQ-031 FIFO storage array need not be reset.

Verification
REQ-032 Sequential commits PC 0x0,0x4,0x8 with pre_pc = PC+4, trace_ready=1 -> three records in order, all redirect=0, retire_cnt=3, redirect_cnt=0.
REQ-033 Commit PC 0x10 pre_pc 0x14, then PC 0x40 pre_pc 0x44 -> second record redirect=1, redirect_cnt=1.
REQ-034 DEPTH=8, trace_ready=0, 10 commits -> level=8, drop_cnt=2, overflow=1, retire_cnt=10; then drain yields the first 8 PCs in order.
REQ-035 level=8, commit and trace_ready both 1 for 3 cycles -> level stays 8, drop_cnt unchanged, 3 oldest records popped, 3 new appended.
REQ-036 Push 5 records, assert rst one cycle with commit=1 -> next cycle level=0, trace_valid=0, all counters 0, overflow=0; next commit has redirect=0.
REQ-037 Preload retire_cnt path by 2^32 commits (or force) -> retire_cnt wraps to 0 with no other side effect.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures retiring {pc, pre_pc, redirect} records into a
// first-word fall-through FIFO and keeps retire/redirect/drop statistics.
module commit_trace_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit,
  input  logic [31:0]              commit_pc,
  input  logic [31:0]              commit_pre_pc,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_pc,
  output logic [31:0]              trace_pre_pc,
  output logic                     trace_redirect,
  output logic [31:0]              retire_cnt,
  output logic [31:0]              redirect_cnt,
  output logic [15:0]              drop_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pre_pc;
    logic        redirect;
  } rec_t;

  rec_t          mem_q [DEPTH];
  rec_t          head;
  rec_t          wr_rec;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   retire_cnt_q, retire_cnt_d;
  logic [31:0]   redirect_cnt_q, redirect_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   last_pre_pc_q, last_pre_pc_d;
  logic          has_prev_q, has_prev_d;

  logic          pop;
  logic          push;
  logic          drop;
  logic          redirect;

  always_comb begin
    pop      = (level_q != '0) && trace_ready;
    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    push     = commit && ((level_q < FULL) || pop);
    drop     = commit && !push;
    redirect = has_prev_q && (commit_pc != last_pre_pc_q);

    wr_rec.pc       = commit_pc;
    wr_rec.pre_pc   = commit_pre_pc;
    wr_rec.redirect = redirect;

    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    level_d        = level_q;
    retire_cnt_d   = retire_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    overflow_d     = overflow_q;
    last_pre_pc_d  = last_pre_pc_q;
    has_prev_d     = has_prev_q;

    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (commit) begin
      retire_cnt_d  = retire_cnt_q + 32'd1;
      last_pre_pc_d = commit_pre_pc;
      has_prev_d    = 1'b1;
      if (redirect) redirect_cnt_d = redirect_cnt_q + 32'd1;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      level_q        <= '0;
      retire_cnt_q   <= '0;
      redirect_cnt_q <= '0;
      drop_cnt_q     <= '0;
      overflow_q     <= 1'b0;
      last_pre_pc_q  <= '0;
      has_prev_q     <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      level_q        <= level_d;
      retire_cnt_q   <= retire_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
      overflow_q     <= overflow_d;
      last_pre_pc_q  <= last_pre_pc_d;
      has_prev_q     <= has_prev_d;
    end
  end

  // Storage is not reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= wr_rec;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (level_q <= FULL);
  end

  assign head           = mem_q[rd_ptr_q];
  assign trace_valid    = (level_q != '0);
  assign trace_pc       = head.pc;
  assign trace_pre_pc   = head.pre_pc;
  assign trace_redirect = head.redirect;
  assign retire_cnt     = retire_cnt_q;
  assign redirect_cnt   = redirect_cnt_q;
  assign drop_cnt       = drop_cnt_q;
  assign overflow       = overflow_q;
  assign level          = level_q;

endmodule
